// File: rtl/gt_pkg.sv
// Shared constants and types for the GTP 8b/10b test-traffic generator.
package gt_pkg;

    localparam logic [7:0] K28_5      = 8'hBC;
    localparam logic [6:0] PRBS7_SEED = 7'h7F;
    localparam int         FIXED_LEN  = 6;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_PRBS7 = 2'd2
    } mode_e;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t ALIGN = 2'd1;
    localparam state_t RUN   = 2'd2;

    // D20.2, D24.2, D20.1, D0.2, D7.5, D3.1
    function automatic logic [7:0] fixed_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h54;
            3'd1:    return 8'h58;
            3'd2:    return 8'h34;
            3'd3:    return 8'h40;
            3'd4:    return 8'hA7;
            default: return 8'h23;
        endcase
    endfunction

    function automatic logic [2:0] fixed_wrap(input int idx);
        return 3'(idx % FIXED_LEN);
    endfunction

endpackage

// File: rtl/gt_frame_gen_if.sv
// Parallel TX word bus between the frame generator and the GTP wrapper.
interface gt_frame_gen_if #(
    parameter int BYTES = 2
);
    logic                 ready;
    logic [1:0]           mode;
    logic [8*BYTES-1:0]   tx_data;
    logic [BYTES-1:0]     txcharisk;
    logic                 frame_start;
    logic                 aligned;
    logic [15:0]          frame_cnt;

    modport master (
        input  ready, mode,
        output tx_data, txcharisk, frame_start, aligned, frame_cnt
    );

    modport slave (
        output ready, mode,
        input  tx_data, txcharisk, frame_start, aligned, frame_cnt
    );
endinterface

// File: rtl/gt_prbs7_step.sv
// Combinational PRBS7 (x^7+x^6+1) advance by NBITS bits; bit 0 of bits_out is produced first.
module gt_prbs7_step #(
    parameter int NBITS = 16
) (
    input  logic [6:0]       state_in,
    output logic [6:0]       state_out,
    output logic [NBITS-1:0] bits_out
);

    logic [6:0] s;
    logic       b;

    always_comb begin
        s        = state_in;
        b        = 1'b0;
        bits_out = '0;
        for (int j = 0; j < NBITS; j++) begin
            b           = s[6] ^ s[5];
            s           = {s[5:0], b};
            bits_out[j] = b;
        end
        state_out = s;
    end

endmodule

// File: rtl/gt_frame_gen.sv
// 8b/10b test-traffic generator: comma alignment burst, then K28.5-led frames
// carrying a FIXED, COUNT or PRBS7 payload.
module gt_frame_gen
    import gt_pkg::*;
#(
    parameter int BYTES       = 2,
    parameter int FRAME_LEN   = 8,
    parameter int ALIGN_WORDS = 4
) (
    input  logic           tx_clk,
    input  logic           reset,
    gt_frame_gen_if.master bus
);

    localparam int W = 8 * BYTES;

    state_t         state_q;
    logic [7:0]     align_cnt_q;
    logic [15:0]    word_idx_q;
    logic [1:0]     mode_q;
    logic [2:0]     tbl_ptr_q;
    logic [7:0]     cnt_q;
    logic [6:0]     lfsr_q;

    logic [W-1:0]     tx_data_p1;
    logic [BYTES-1:0] txcharisk_p1;
    logic             frame_start_p1;
    logic             aligned_p1;
    logic [15:0]      frame_cnt_p1;

    logic [6:0]     lfsr_nxt;
    logic [W-1:0]   prbs_word;
    logic [W-1:0]   fixed_word;
    logic [W-1:0]   count_word;
    logic [2:0]     tbl_ptr_nxt;

    gt_prbs7_step #(.NBITS(W)) u_prbs (
        .state_in  (lfsr_q),
        .state_out (lfsr_nxt),
        .bits_out  (prbs_word)
    );

    always_comb begin
        fixed_word = '0;
        count_word = '0;
        for (int i = 0; i < BYTES; i++) begin
            fixed_word[8*i +: 8] = fixed_byte(fixed_wrap(int'(tbl_ptr_q) + i));
            count_word[8*i +: 8] = 8'(cnt_q * 8'(BYTES)) + 8'(i);
        end
        tbl_ptr_nxt = fixed_wrap(int'(tbl_ptr_q) + BYTES);
    end

    // State and output register stage; outputs lag the state by one edge.
    always_ff @(posedge tx_clk) begin
        if (reset || !bus.ready) begin
            state_q        <= IDLE;
            align_cnt_q    <= '0;
            word_idx_q     <= '0;
            mode_q         <= '0;
            tbl_ptr_q      <= '0;
            cnt_q          <= '0;
            lfsr_q         <= PRBS7_SEED;
            tx_data_p1     <= '0;
            txcharisk_p1   <= '0;
            frame_start_p1 <= 1'b0;
            aligned_p1     <= 1'b0;
            frame_cnt_p1   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q        <= ALIGN;
                    align_cnt_q    <= '0;
                    cnt_q          <= '0;
                    lfsr_q         <= PRBS7_SEED;
                    tx_data_p1     <= '0;
                    txcharisk_p1   <= '0;
                    frame_start_p1 <= 1'b0;
                    aligned_p1     <= 1'b0;
                    frame_cnt_p1   <= '0;
                end
                ALIGN: begin
                    tx_data_p1     <= {BYTES{K28_5}};
                    txcharisk_p1   <= '1;
                    frame_start_p1 <= 1'b0;
                    aligned_p1     <= 1'b0;
                    if (align_cnt_q == 8'(ALIGN_WORDS - 1)) begin
                        state_q    <= RUN;
                        word_idx_q <= '0;
                        mode_q     <= bus.mode;
                    end else begin
                        align_cnt_q <= align_cnt_q + 8'd1;
                    end
                end
                RUN: begin
                    aligned_p1 <= 1'b1;
                    if (word_idx_q == '0) begin
                        tx_data_p1     <= {BYTES{K28_5}};
                        txcharisk_p1   <= '1;
                        frame_start_p1 <= 1'b1;
                        frame_cnt_p1   <= frame_cnt_p1 + 16'd1;
                        mode_q         <= bus.mode;
                        tbl_ptr_q      <= '0;
                    end else begin
                        txcharisk_p1   <= '0;
                        frame_start_p1 <= 1'b0;
                        // Each generator only advances while its own pattern is selected.
                        case (mode_q)
                            MODE_COUNT: begin
                                tx_data_p1 <= count_word;
                                cnt_q      <= cnt_q + 8'd1;
                            end
                            MODE_PRBS7: begin
                                tx_data_p1 <= prbs_word;
                                lfsr_q     <= lfsr_nxt;
                            end
                            default: begin
                                tx_data_p1 <= fixed_word;
                                tbl_ptr_q  <= tbl_ptr_nxt;
                            end
                        endcase
                    end
                    if (word_idx_q == 16'(FRAME_LEN - 1)) begin
                        word_idx_q <= '0;
                    end else begin
                        word_idx_q <= word_idx_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data     = tx_data_p1;
    assign bus.txcharisk   = txcharisk_p1;
    assign bus.frame_start = frame_start_p1;
    assign bus.aligned     = aligned_p1;
    assign bus.frame_cnt   = frame_cnt_p1;

endmodule

// File: tb/tb_gt_frame_gen.sv
// Bench for gt_frame_gen: bring-up vector table, directed corner cases,
// randomized traffic against a word-level reference model, and frame_cnt wrap.
module tb_gt_frame_gen;

    localparam int B = 2;
    localparam int F = 8;
    localparam int A = 4;

    logic tx_clk = 1'b0;
    logic rst    = 1'b1;
    logic rst_w  = 1'b1;

    always #5 tx_clk = ~tx_clk;

    gt_frame_gen_if #(.BYTES(2)) bus2 ();
    gt_frame_gen_if #(.BYTES(4)) bus4 ();
    gt_frame_gen_if #(.BYTES(2)) busw ();

    gt_frame_gen #(.BYTES(2), .FRAME_LEN(F), .ALIGN_WORDS(A)) dut2 (
        .tx_clk (tx_clk), .reset (rst), .bus (bus2.master));
    gt_frame_gen #(.BYTES(4), .FRAME_LEN(8), .ALIGN_WORDS(4)) dut4 (
        .tx_clk (tx_clk), .reset (rst), .bus (bus4.master));
    gt_frame_gen #(.BYTES(2), .FRAME_LEN(2), .ALIGN_WORDS(1)) dutw (
        .tx_clk (tx_clk), .reset (rst_w), .bus (busw.master));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rdy;
        logic [1:0]  md;
        logic [15:0] d;
        logic [1:0]  k;
        logic        fs;
        logic        al;
        logic [15:0] fc;
    } vec_t;
    vec_t tv[$];

    // Reference model state (word-level view of the spec rules)
    int          m_r;
    int          m_c;
    logic [6:0]  m_lfsr;
    logic [1:0]  m_mode;
    logic [15:0] e_d;
    logic [1:0]  e_k;
    logic        e_fs, e_al;
    logic [15:0] e_fc;

    function automatic logic [7:0] tbl(input int i);
        case (i)
            0: return 8'h54;
            1: return 8'h58;
            2: return 8'h34;
            3: return 8'h40;
            4: return 8'hA7;
            default: return 8'h23;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic rdy, input logic [1:0] md);
        int  k, widx;
        logic b;
        e_d = '0; e_k = '0; e_fs = 1'b0; e_al = 1'b0; e_fc = '0;
        if (r || !rdy) begin
            m_r = 0;
            return;
        end
        m_r++;
        if (m_r == 1) begin
            m_c    = 0;
            m_lfsr = 7'h7F;
        end else if (m_r <= A + 1) begin
            e_d = 16'hBCBC; e_k = 2'b11;
        end else begin
            k    = m_r - A - 2;
            widx = k % F;
            e_al = 1'b1;
            e_fc = 16'(k / F + 1);
            if (widx == 0) begin
                e_d = 16'hBCBC; e_k = 2'b11; e_fs = 1'b1;
                m_mode = md;
            end else if (m_mode == 2'd1) begin
                for (int i = 0; i < B; i++) e_d[8*i +: 8] = 8'(m_c * B + i);
                m_c++;
            end else if (m_mode == 2'd2) begin
                for (int j = 0; j < 8 * B; j++) begin
                    b      = m_lfsr[6] ^ m_lfsr[5];
                    m_lfsr = {m_lfsr[5:0], b};
                    e_d[j] = b;
                end
            end else begin
                for (int i = 0; i < B; i++) e_d[8*i +: 8] = tbl(((widx - 1) * B + i) % 6);
            end
        end
    endtask

    task automatic cyc(input logic r, input logic rdy, input logic [1:0] md);
        rst        = r;
        bus2.ready = rdy;
        bus2.mode  = md;
        @(posedge tx_clk);
        model_step(r, rdy, md);
        #1;
    endtask

    task automatic chk2(input string name, input logic [15:0] d, input logic [1:0] k,
                        input logic fs, input logic al, input logic [15:0] fc);
        checks++;
        if ({bus2.tx_data, bus2.txcharisk, bus2.frame_start, bus2.aligned, bus2.frame_cnt}
            !== {d, k, fs, al, fc}) begin
            errors++;
            $display("FAIL %s: got data=%h k=%b fs=%b al=%b cnt=%h, expected data=%h k=%b fs=%b al=%b cnt=%h",
                     name, bus2.tx_data, bus2.txcharisk, bus2.frame_start, bus2.aligned,
                     bus2.frame_cnt, d, k, fs, al, fc);
        end
    endtask

    task automatic chk_model(input string name);
        chk2(name, e_d, e_k, e_fs, e_al, e_fc);
    endtask

    task automatic chk4(input string name, input logic [31:0] d, input logic [3:0] k,
                        input logic fs, input logic al, input logic [15:0] fc);
        checks++;
        if ({bus4.tx_data, bus4.txcharisk, bus4.frame_start, bus4.aligned, bus4.frame_cnt}
            !== {d, k, fs, al, fc}) begin
            errors++;
            $display("FAIL %s: got data=%h k=%b fs=%b al=%b cnt=%h, expected data=%h k=%b fs=%b al=%b cnt=%h",
                     name, bus4.tx_data, bus4.txcharisk, bus4.frame_start, bus4.aligned,
                     bus4.frame_cnt, d, k, fs, al, fc);
        end
    endtask

    task automatic run_main();
        logic [31:0] w4;
        logic [1:0]  md;
        logic        rdy, r;
        bus4.ready = 1'b0;
        bus4.mode  = 2'd1;

        // Reset and idle
        cyc(1'b1, 1'b0, 2'd0);
        cyc(1'b1, 1'b0, 2'd0);
        chk2("reset_state", 16'h0, 2'b00, 1'b0, 1'b0, 16'h0);
        chk4("reset_state4", 32'h0, 4'h0, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 2'd0);
        chk2("idle_ready_low", 16'h0, 2'b00, 1'b0, 1'b0, 16'h0);

        // BYTES=4 COUNT bring-up
        bus4.ready = 1'b1;
        for (int s = 1; s <= 15; s++) begin
            cyc(1'b0, 1'b0, 2'd0);
            chk_model("idle_hold");
            if (s == 1) chk4("c4_idle", 32'h0, 4'h0, 1'b0, 1'b0, 16'h0);
            else if (s <= 5) chk4("c4_align", 32'hBCBCBCBC, 4'hF, 1'b0, 1'b0, 16'h0);
            else if (s == 6) chk4("c4_comma1", 32'hBCBCBCBC, 4'hF, 1'b1, 1'b1, 16'd1);
            else if (s <= 13) begin
                w4 = {8'(4*(s-7)+3), 8'(4*(s-7)+2), 8'(4*(s-7)+1), 8'(4*(s-7))};
                chk4("c4_payload", w4, 4'h0, 1'b0, 1'b1, 16'd1);
            end else if (s == 14) chk4("c4_comma2", 32'hBCBCBCBC, 4'hF, 1'b1, 1'b1, 16'd2);
            else chk4("c4_frame2_first", 32'h1F1E1D1C, 4'h0, 1'b0, 1'b1, 16'd2);
        end
        bus4.ready = 1'b0;

        // FIXED bring-up vector table
        tv.push_back('{1'b1, 2'd0, 16'h0000, 2'b00, 1'b0, 1'b0, 16'd0});
        for (int i = 0; i < 4; i++)
            tv.push_back('{1'b1, 2'd0, 16'hBCBC, 2'b11, 1'b0, 1'b0, 16'd0});
        tv.push_back('{1'b1, 2'd0, 16'hBCBC, 2'b11, 1'b1, 1'b1, 16'd1});
        for (int i = 0; i < 7; i++) begin
            case (i % 3)
                0: tv.push_back('{1'b1, 2'd0, 16'h5854, 2'b00, 1'b0, 1'b1, 16'd1});
                1: tv.push_back('{1'b1, 2'd0, 16'h4034, 2'b00, 1'b0, 1'b1, 16'd1});
                default: tv.push_back('{1'b1, 2'd0, 16'h23A7, 2'b00, 1'b0, 1'b1, 16'd1});
            endcase
        end
        tv.push_back('{1'b1, 2'd0, 16'hBCBC, 2'b11, 1'b1, 1'b1, 16'd2});
        foreach (tv[i]) begin
            cyc(1'b0, tv[i].rdy, tv[i].md);
            chk2($sformatf("vec%0d", i), tv[i].d, tv[i].k, tv[i].fs, tv[i].al, tv[i].fc);
        end

        // Mode change FIXED->COUNT at payload word 3
        cyc(1'b0, 1'b1, 2'd0); chk_model("modesw_w1");
        cyc(1'b0, 1'b1, 2'd0); chk_model("modesw_w2");
        cyc(1'b0, 1'b1, 2'd1); chk2("modesw_cont", 16'h23A7, 2'b00, 1'b0, 1'b1, 16'd2);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 2'd1); chk_model("modesw_rest");
        end
        cyc(1'b0, 1'b1, 2'd1); chk2("modesw_next", 16'h0100, 2'b00, 1'b0, 1'b1, 16'd3);

        // Ready drop mid-frame and recovery
        cyc(1'b0, 1'b1, 2'd1); chk_model("pre_drop");
        cyc(1'b0, 1'b0, 2'd1); chk2("ready_drop", 16'h0, 2'b00, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 2'd1); chk_model("reraise_idle");
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 2'd1);
            chk2("reraise_align", 16'hBCBC, 2'b11, 1'b0, 1'b0, 16'h0);
        end
        cyc(1'b0, 1'b1, 2'd1); chk2("reraise_comma", 16'hBCBC, 2'b11, 1'b1, 1'b1, 16'd1);
        cyc(1'b0, 1'b1, 2'd1); chk2("count_restart", 16'h0100, 2'b00, 1'b0, 1'b1, 16'd1);

        // One-cycle reset while running
        cyc(1'b0, 1'b1, 2'd1); chk_model("pre_reset");
        cyc(1'b1, 1'b1, 2'd1); chk2("reset_run", 16'h0, 2'b00, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 1 + A + 2 * F; i++) begin
            cyc(1'b0, 1'b1, 2'd1); chk_model("after_reset");
        end

        // PRBS7 from a fresh bring-up, 1000 frames
        cyc(1'b0, 1'b0, 2'd2); chk_model("prbs_drop");
        for (int i = 0; i < 1 + A + 1; i++) begin
            cyc(1'b0, 1'b1, 2'd2); chk_model("prbs_bringup");
        end
        cyc(1'b0, 1'b1, 2'd2); chk2("prbs_first", 16'h3040, 2'b00, 1'b0, 1'b1, 16'd1);
        for (int i = 0; i < 1000 * F - 2; i++) begin
            cyc(1'b0, 1'b1, 2'd2); chk_model("prbs_run");
        end

        // Randomized traffic
        md = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 49) != 0);
            r   = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0) md = 2'($urandom_range(0, 3));
            cyc(r, rdy, md);
            chk_model("random");
        end
    endtask

    task automatic run_wrap();
        int n;
        busw.mode  = 2'd0;
        busw.ready = 1'b0;
        rst_w      = 1'b1;
        repeat (2) @(posedge tx_clk);
        #1;
        rst_w      = 1'b0;
        busw.ready = 1'b1;
        n = 0;
        for (int cy = 0; cy < 140000 && n < 65536; cy++) begin
            @(posedge tx_clk);
            #1;
            if (busw.frame_start === 1'b1) begin
                n++;
                checks++;
                if (busw.frame_cnt !== 16'(n)) begin
                    errors++;
                    $display("FAIL wrap_cnt: frame %0d got cnt=%h expected %h", n, busw.frame_cnt, 16'(n));
                end
            end
        end
        checks++;
        if (n < 65536) begin
            errors++;
            $display("FAIL wrap_timeout: frames seen %0d, required 65536", n);
        end
    endtask

    initial begin
        fork
            run_main();
            run_wrap();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
